// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - serial bit stream to parallel word receiver
// Bits arrive under valid/ready; completed words are held until the consumer takes them.
module serial_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             msb_first,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] sr_base;
  logic             order_q;
  logic             order_eff;
  logic             accept;
  logic             last_bit;

  assign accept   = s_valid & s_ready;
  assign last_bit = (state == COLLECT) && (bit_cnt == LAST_CNT);

  // The first bit of a word (from IDLE or FULL) uses the live msb_first; later bits use the latched order.
  always_comb begin
    order_eff = order_q;
    sr_base   = sr;
    if (state != COLLECT) begin
      order_eff = msb_first;
      sr_base   = '0;
    end
    if (order_eff) begin
      sr_next = {sr_base[WIDTH-2:0], s_data};
    end else begin
      sr_next = {s_data, sr_base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && last_bit) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (p_ready) begin
          state_next = accept ? COLLECT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    p_valid = (state == FULL);
    s_ready = rst && ((state != FULL) || p_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      order_q <= 1'b0;
      p_data  <= '0;
    end else if (accept) begin
      if (last_bit) begin
        p_data  <= sr_next;
        sr      <= '0;
        bit_cnt <= '0;
      end else begin
        sr      <= sr_next;
        bit_cnt <= (state == COLLECT) ? bit_cnt + CNT_W'(1) : CNT_W'(1);
      end
      if (state != COLLECT) begin
        order_q <= msb_first;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb/tb_serial_word_receiver.sv - directed bench for serial_word_receiver
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_data;
  logic       msb_first;
  logic       s_ready;
  logic [3:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic [2:0] bit_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  serial_word_receiver #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .msb_first (msb_first),
    .s_ready   (s_ready),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    s_valid = 1'b1;
    s_data  = b;
    cyc();
  endtask

  initial begin
    rst       = 1'b0;
    s_valid   = 1'b1;
    s_data    = 1'b1;
    msb_first = 1'b0;
    p_ready   = 1'b1;
    @(negedge clk);

    // Reset with s_valid high
    cyc();
    cyc();
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    chk("rst_p_data", 32'(p_data), 32'h0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    chk("rst_release_s_ready", 32'(s_ready), 32'd1);

    // MSB-first with a 2-cycle gap
    msb_first = 1'b1;
    send(1'b1);
    chk("msb_cnt1", 32'(bit_cnt), 32'd1);
    send(1'b1);
    s_valid = 1'b0;
    cyc();
    cyc();
    chk("msb_gap_cnt", 32'(bit_cnt), 32'd2);
    chk("msb_gap_p_valid", 32'(p_valid), 32'd0);
    send(1'b0);
    chk("msb_pre_last_p_valid", 32'(p_valid), 32'd0);
    send(1'b1);
    s_valid = 1'b0;
    chk("msb_p_valid", 32'(p_valid), 32'd1);
    chk("msb_p_data", 32'(p_data), 32'hD);
    chk("msb_full_cnt", 32'(bit_cnt), 32'd0);
    cyc();
    chk("msb_consumed", 32'(p_valid), 32'd0);
    chk("msb_idle_s_ready", 32'(s_ready), 32'd1);

    // LSB-first back-to-back words
    msb_first = 1'b0;
    send(1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    chk("lsb_w1_p_valid", 32'(p_valid), 32'd1);
    chk("lsb_w1_p_data", 32'(p_data), 32'hD);
    chk("lsb_w1_s_ready", 32'(s_ready), 32'd1);
    send(1'b0);
    chk("lsb_w2_start_p_valid", 32'(p_valid), 32'd0);
    chk("lsb_w2_start_cnt", 32'(bit_cnt), 32'd1);
    send(1'b0);
    send(1'b1);
    send(1'b0);
    s_valid = 1'b0;
    chk("lsb_w2_p_valid", 32'(p_valid), 32'd1);
    chk("lsb_w2_p_data", 32'(p_data), 32'h4);
    cyc();
    chk("lsb_w2_consumed", 32'(p_valid), 32'd0);

    // Backpressure holding word 1101
    send(1'b1);
    send(1'b0);
    send(1'b1);
    p_ready = 1'b0;
    send(1'b1);
    s_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      cyc();
      chk("bp_p_data", 32'(p_data), 32'hD);
      chk("bp_p_valid", 32'(p_valid), 32'd1);
      chk("bp_cnt", 32'(bit_cnt), 32'd0);
    end
    p_ready = 1'b1;
    #1;
    chk("bp_release_s_ready", 32'(s_ready), 32'd1);
    cyc();
    chk("bp_release_cnt", 32'(bit_cnt), 32'd1);
    chk("bp_release_p_valid", 32'(p_valid), 32'd0);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    s_valid = 1'b0;
    chk("bp_next_word", 32'(p_data), 32'h1);
    chk("bp_next_p_valid", 32'(p_valid), 32'd1);
    cyc();

    // Order change mid-word: first bit fixes MSB-first
    msb_first = 1'b1;
    send(1'b1);
    send(1'b0);
    msb_first = 1'b0;
    send(1'b0);
    send(1'b1);
    s_valid = 1'b0;
    chk("order_p_data", 32'(p_data), 32'h9);
    chk("order_p_valid", 32'(p_valid), 32'd1);
    cyc();

    // Reset mid-word discards the partial word
    send(1'b1);
    send(1'b1);
    chk("rmw_cnt", 32'(bit_cnt), 32'd2);
    s_valid = 1'b0;
    rst     = 1'b0;
    #1;
    chk("rmw_s_ready", 32'(s_ready), 32'd0);
    cyc();
    chk("rmw_cnt_cleared", 32'(bit_cnt), 32'd0);
    chk("rmw_p_valid", 32'(p_valid), 32'd0);
    rst       = 1'b1;
    msb_first = 1'b1;
    send(1'b0);
    send(1'b1);
    send(1'b1);
    chk("rmw_no_pulse", 32'(p_valid), 32'd0);
    send(1'b0);
    s_valid = 1'b0;
    chk("rmw_p_valid_final", 32'(p_valid), 32'd1);
    chk("rmw_p_data", 32'(p_data), 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
